// File: rtl/segre_dmem_ctrl.sv
// segre_dmem_ctrl: main-memory controller that sits below the data cache.
// It serves line fills and dirty-line writebacks against a line-granular
// backing store, and models a fixed access latency for every line access.
// When a writeback and a fill arrive together, the writeback is done first.
// This means a fill of the line just evicted returns the freshly written data.
module segre_dmem_ctrl #(
    parameter int CACHE_LINE_SIZE_BYTES = 16,
    parameter int WORD_SIZE             = 32,
    parameter int MEM_LATENCY           = 4,
    parameter int MEM_DEPTH_LINES       = 1024
) (
    input  logic                               clk_i,
    input  logic                               rsn_i,
    input  logic                               rd_req_i,
    input  logic                               wr_req_i,
    input  logic [WORD_SIZE-1:0]               addr_i,
    input  logic [WORD_SIZE-1:0]               wb_addr_i,
    input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] wr_line_i,
    output logic [CACHE_LINE_SIZE_BYTES*8-1:0] rd_line_o,
    output logic                               mem_ready_o,
    output logic                               wb_done_o,
    output logic                               busy_o
);

    localparam int LINE_BITS = CACHE_LINE_SIZE_BYTES * 8;
    localparam int OFS       = $clog2(CACHE_LINE_SIZE_BYTES);
    localparam int IDX_W     = $clog2(MEM_DEPTH_LINES);
    localparam int CNT_W     = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RD,
        RESP,
        HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pend_rd_q, pend_rd_d;
    logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]       wb_idx_q, wb_idx_d;
    logic [LINE_BITS-1:0]   wb_line_q, wb_line_d;
    logic [LINE_BITS-1:0]   rd_line_q;
    logic                   mem_ready_q, mem_ready_d;
    logic                   wb_done_q, wb_done_d;
    logic                   rd_load;
    logic                   store_we;

    logic [LINE_BITS-1:0]   store_q [MEM_DEPTH_LINES];

    // The byte-offset bits and the bits above the store depth are ignored.
    // As a result, addresses wrap modulo the store size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[OFS-1:0], addr_i[WORD_SIZE-1:OFS+IDX_W],
                                wb_addr_i[OFS-1:0], wb_addr_i[WORD_SIZE-1:OFS+IDX_W]};

    assign rd_line_o   = rd_line_q;
    assign mem_ready_o = mem_ready_q;
    assign wb_done_o   = wb_done_q;
    assign busy_o      = (state_q != IDLE);

    // Next-state logic: accept requests only in IDLE, count down the latency, and schedule the response pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_rd_d   = pend_rd_q;
        rd_idx_d    = rd_idx_q;
        wb_idx_d    = wb_idx_q;
        wb_line_d   = wb_line_q;
        mem_ready_d = 1'b0;
        wb_done_d   = 1'b0;
        rd_load     = 1'b0;
        store_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wr_req_i) begin
                    wb_idx_d  = wb_addr_i[OFS +: IDX_W];
                    wb_line_d = wr_line_i;
                    pend_rd_d = rd_req_i;
                    if (rd_req_i) begin
                        rd_idx_d = addr_i[OFS +: IDX_W];
                    end
                    cnt_d   = CNT_RELOAD;
                    state_d = WB;
                end else if (rd_req_i) begin
                    rd_idx_d = addr_i[OFS +: IDX_W];
                    cnt_d    = CNT_RELOAD;
                    state_d  = RD;
                end
            end
            WB: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    store_we  = ~rsn_i;
                    wb_done_d = 1'b1;
                    if (pend_rd_q) begin
                        cnt_d   = CNT_RELOAD;
                        state_d = RD;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            RD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rd_load     = 1'b1;
                    mem_ready_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, request latches, fill data and response pulses, all cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_rd_q   <= 1'b0;
            rd_idx_q    <= '0;
            wb_idx_q    <= '0;
            wb_line_q   <= '0;
            rd_line_q   <= '0;
            mem_ready_q <= 1'b0;
            wb_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_rd_q   <= pend_rd_d;
            rd_idx_q    <= rd_idx_d;
            wb_idx_q    <= wb_idx_d;
            wb_line_q   <= wb_line_d;
            mem_ready_q <= mem_ready_d;
            wb_done_q   <= wb_done_d;
            if (rd_load) begin
                rd_line_q <= store_q[rd_idx_q];
            end
        end
    end

    // Backing store write port; its contents survive reset.
    always_ff @(posedge clk_i) begin
        if (store_we) begin
            store_q[wb_idx_q] <= wb_line_q;
        end
    end

endmodule

// File: tb/tb_segre_dmem_ctrl.sv
// Self-checking bench for segre_dmem_ctrl.
// A reference model of the line store and of the per-transaction event timing
// is used to check scripted corner cases and a randomized transaction stream.
module tb_segre_dmem_ctrl;

    localparam int LINE_BYTES = 16;
    localparam int LINE_BITS  = LINE_BYTES * 8;
    localparam int WORD       = 32;
    localparam int LAT        = 4;
    localparam int DEPTH      = 1024;
    localparam int OBS_N      = 32;

    logic                 clk = 1'b0;
    logic                 rsn;
    logic                 rdReq;
    logic                 wrReq;
    logic [WORD-1:0]      addr;
    logic [WORD-1:0]      wbAddr;
    logic [LINE_BITS-1:0] wrLine;
    logic [LINE_BITS-1:0] rdLine;
    logic                 memReady;
    logic                 wbDone;
    logic                 busy;

    int nVec = 0;
    int nErr = 0;

    logic [LINE_BITS-1:0] modelMem [DEPTH];
    logic [LINE_BITS-1:0] modelRdLine;

    logic                 obsBusy  [OBS_N];
    logic                 obsReady [OBS_N];
    logic                 obsDone  [OBS_N];
    logic [LINE_BITS-1:0] obsLine  [OBS_N];

    // Free-running clock.
    always #5 clk = ~clk;

    segre_dmem_ctrl #(
        .CACHE_LINE_SIZE_BYTES (LINE_BYTES),
        .WORD_SIZE             (WORD),
        .MEM_LATENCY           (LAT),
        .MEM_DEPTH_LINES       (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rsn_i       (rsn),
        .rd_req_i    (rdReq),
        .wr_req_i    (wrReq),
        .addr_i      (addr),
        .wb_addr_i   (wbAddr),
        .wr_line_i   (wrLine),
        .rd_line_o   (rdLine),
        .mem_ready_o (memReady),
        .wb_done_o   (wbDone),
        .busy_o      (busy)
    );

    function automatic int lineIdx(input logic [WORD-1:0] a);
        return int'((a / LINE_BYTES) % DEPTH);
    endfunction

    function automatic logic [LINE_BITS-1:0] randLine();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one request in C0 (at a falling edge) and record outputs for cycles C0..Cncyc.
    // The fill request is held until mem_ready is seen, unless holdRd keeps it up for the whole window.
    task automatic runTxn(input bit wr, input bit rd, input logic [WORD-1:0] wa,
                          input logic [WORD-1:0] ra, input logic [LINE_BITS-1:0] line,
                          input bit holdRd, input int ncyc);
        @(negedge clk);
        obsBusy[0]  = busy;
        obsReady[0] = memReady;
        obsDone[0]  = wbDone;
        obsLine[0]  = rdLine;
        wrReq  = wr;
        rdReq  = rd;
        wbAddr = wa;
        addr   = ra;
        wrLine = line;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) wrReq = 1'b0;
            obsBusy[k]  = busy;
            obsReady[k] = memReady;
            obsDone[k]  = wbDone;
            obsLine[k]  = rdLine;
            if (memReady && !holdRd) rdReq = 1'b0;
        end
        rdReq = 1'b0;
        wrReq = 1'b0;
    endtask

    task automatic test_reset();
        rsn = 1'b1; rdReq = 1'b0; wrReq = 1'b0;
        addr = '0; wbAddr = '0; wrLine = '0;
        repeat (3) @(negedge clk);
        nVec++; if (busy !== 1'b0)     begin nErr++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        nVec++; if (memReady !== 1'b0) begin nErr++; $display("[TB] FAIL reset_ready got %0b want 0", memReady); end
        nVec++; if (wbDone !== 1'b0)   begin nErr++; $display("[TB] FAIL reset_done got %0b want 0", wbDone); end
        nVec++; if (rdLine !== '0)     begin nErr++; $display("[TB] FAIL reset_line got %h want 0", rdLine); end
        rsn = 1'b0;
        modelRdLine = '0;
    endtask

    task automatic test_write_only();
        logic [LINE_BITS-1:0] line;
        line = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        runTxn(1'b1, 1'b0, 32'h100, 32'h0, line, 1'b0, 8);
        modelMem[lineIdx(32'h100)] = line;
        for (int k = 0; k <= 8; k++) begin
            nVec++;
            if (obsBusy[k] !== (k >= 1 && k <= LAT + 1)) begin
                nErr++; $display("[TB] FAIL wr_busy C%0d got %0b want %0b", k, obsBusy[k], (k >= 1 && k <= LAT + 1));
            end
            nVec++;
            if (obsDone[k] !== (k == LAT + 1)) begin
                nErr++; $display("[TB] FAIL wr_done C%0d got %0b want %0b", k, obsDone[k], (k == LAT + 1));
            end
            nVec++;
            if (obsReady[k] !== 1'b0) begin
                nErr++; $display("[TB] FAIL wr_ready C%0d got %0b want 0", k, obsReady[k]);
            end
        end
    endtask

    task automatic test_read_only();
        runTxn(1'b0, 1'b1, 32'h0, 32'h104, '0, 1'b0, 8);
        modelRdLine = modelMem[lineIdx(32'h104)];
        for (int k = 0; k <= 8; k++) begin
            nVec++;
            if (obsReady[k] !== (k == LAT + 1)) begin
                nErr++; $display("[TB] FAIL rd_ready C%0d got %0b want %0b", k, obsReady[k], (k == LAT + 1));
            end
            nVec++;
            if (obsBusy[k] !== (k >= 1 && k <= LAT + 2)) begin
                nErr++; $display("[TB] FAIL rd_busy C%0d got %0b want %0b", k, obsBusy[k], (k >= 1 && k <= LAT + 2));
            end
        end
        nVec++;
        if (obsLine[LAT + 1] !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
            nErr++; $display("[TB] FAIL rd_line got %h want 0f0e0d0c0b0a09080706050403020100", obsLine[LAT + 1]);
        end
    endtask

    task automatic test_write_read();
        logic [LINE_BITS-1:0] line;
        line = {16{8'hAA}};
        runTxn(1'b1, 1'b1, 32'h200, 32'h200, line, 1'b0, 14);
        modelMem[lineIdx(32'h200)] = line;
        modelRdLine = line;
        for (int k = 0; k <= 14; k++) begin
            nVec++;
            if (obsDone[k] !== (k == LAT + 1)) begin
                nErr++; $display("[TB] FAIL wrrd_done C%0d got %0b want %0b", k, obsDone[k], (k == LAT + 1));
            end
            nVec++;
            if (obsReady[k] !== (k == 2 * LAT + 1)) begin
                nErr++; $display("[TB] FAIL wrrd_ready C%0d got %0b want %0b", k, obsReady[k], (k == 2 * LAT + 1));
            end
            nVec++;
            if (obsBusy[k] !== (k >= 1 && k <= 2 * LAT + 2)) begin
                nErr++; $display("[TB] FAIL wrrd_busy C%0d got %0b want %0b", k, obsBusy[k], (k >= 1 && k <= 2 * LAT + 2));
            end
        end
        nVec++;
        if (obsLine[2 * LAT + 1] !== line) begin
            nErr++; $display("[TB] FAIL wrrd_line got %h want %h", obsLine[2 * LAT + 1], line);
        end
    endtask

    task automatic test_hold_rd();
        // The request stays up: the first fill returns in C(L+1); after the dead cycle and the
        // return to idle in C(L+3), the second fill is accepted there and returns L+1 cycles later.
        int second;
        second = (LAT + 3) + LAT + 1;
        runTxn(1'b0, 1'b1, 32'h0, 32'h100, '0, 1'b1, 14);
        modelRdLine = modelMem[lineIdx(32'h100)];
        for (int k = 0; k <= 14; k++) begin
            nVec++;
            if (obsReady[k] !== (k == LAT + 1 || k == second)) begin
                nErr++; $display("[TB] FAIL hold_ready C%0d got %0b want %0b", k, obsReady[k], (k == LAT + 1 || k == second));
            end
            nVec++;
            if (obsBusy[k] !== ((k >= 1 && k <= LAT + 2) || (k >= LAT + 4 && k <= second + 1))) begin
                nErr++; $display("[TB] FAIL hold_busy C%0d got %0b want %0b", k, obsBusy[k],
                                 ((k >= 1 && k <= LAT + 2) || (k >= LAT + 4 && k <= second + 1)));
            end
        end
        nVec++;
        if (obsLine[second] !== modelRdLine) begin
            nErr++; $display("[TB] FAIL hold_line got %h want %h", obsLine[second], modelRdLine);
        end
    endtask

    task automatic test_wrap();
        logic [LINE_BITS-1:0] line;
        line = randLine();
        runTxn(1'b1, 1'b0, 32'h4100, 32'h0, line, 1'b0, 8);
        modelMem[lineIdx(32'h4100)] = line;
        runTxn(1'b0, 1'b1, 32'h0, 32'h0100, '0, 1'b0, 8);
        modelRdLine = modelMem[lineIdx(32'h0100)];
        nVec++;
        if (obsReady[LAT + 1] !== 1'b1) begin
            nErr++; $display("[TB] FAIL wrap_ready got %0b want 1", obsReady[LAT + 1]);
        end
        nVec++;
        if (obsLine[LAT + 1] !== modelRdLine) begin
            nErr++; $display("[TB] FAIL wrap_line got %h want %h", obsLine[LAT + 1], modelRdLine);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [LINE_BITS-1:0] oldLine;
        logic [LINE_BITS-1:0] newLine;
        oldLine = randLine();
        newLine = ~oldLine;
        runTxn(1'b1, 1'b0, 32'h300, 32'h0, oldLine, 1'b0, 8);
        modelMem[lineIdx(32'h300)] = oldLine;
        @(negedge clk);
        wrReq = 1'b1; wbAddr = 32'h300; wrLine = newLine;
        @(negedge clk);
        wrReq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rsn = 1'b1;
        @(negedge clk);
        nVec++; if (busy !== 1'b0)   begin nErr++; $display("[TB] FAIL rstmid_busy got %0b want 0", busy); end
        nVec++; if (wbDone !== 1'b0) begin nErr++; $display("[TB] FAIL rstmid_done got %0b want 0", wbDone); end
        nVec++; if (rdLine !== '0)   begin nErr++; $display("[TB] FAIL rstmid_line got %h want 0", rdLine); end
        rsn = 1'b0;
        modelRdLine = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nVec++;
            if (wbDone !== 1'b0 || busy !== 1'b0) begin
                nErr++; $display("[TB] FAIL rstmid_quiet cyc %0d done %0b busy %0b want 0 0", k, wbDone, busy);
            end
        end
        runTxn(1'b0, 1'b1, 32'h0, 32'h300, '0, 1'b0, 8);
        modelRdLine = modelMem[lineIdx(32'h300)];
        nVec++;
        if (obsLine[LAT + 1] !== modelRdLine) begin
            nErr++; $display("[TB] FAIL rstmid_store got %h want %h", obsLine[LAT + 1], modelRdLine);
        end
    endtask

    task automatic test_random();
        int pool [6];
        int ncyc;
        ncyc = 2 * LAT + 4;
        for (int i = 0; i < 6; i++) begin
            logic [WORD-1:0] a;
            logic [LINE_BITS-1:0] line;
            pool[i] = int'($urandom_range(0, DEPTH - 1));
            a = WORD'(pool[i] * LINE_BYTES);
            line = randLine();
            runTxn(1'b1, 1'b0, a, 32'h0, line, 1'b0, ncyc);
            modelMem[pool[i]] = line;
        end
        for (int t = 0; t < 40; t++) begin
            int kind;
            bit wr;
            bit rd;
            int expReady;
            int expDone;
            int lastBusy;
            logic [WORD-1:0] wa;
            logic [WORD-1:0] ra;
            logic [LINE_BITS-1:0] line;
            kind = int'($urandom_range(0, 2));
            wr = (kind != 1);
            rd = (kind != 0);
            wa = ($urandom & 32'hFFFF_C000) | WORD'(pool[$urandom_range(0, 5)] * LINE_BYTES) | ($urandom & 32'hF);
            ra = ($urandom & 32'hFFFF_C000) | WORD'(pool[$urandom_range(0, 5)] * LINE_BYTES) | ($urandom & 32'hF);
            line = randLine();
            runTxn(wr, rd, wa, ra, line, 1'b0, ncyc);
            if (wr) modelMem[lineIdx(wa)] = line;
            if (rd) modelRdLine = modelMem[lineIdx(ra)];
            expDone  = wr ? LAT + 1 : -1;
            expReady = rd ? (wr ? 2 * LAT + 1 : LAT + 1) : -1;
            lastBusy = rd ? expReady + 1 : expDone;
            for (int k = 0; k <= ncyc; k++) begin
                nVec++;
                if (obsReady[k] !== (k == expReady)) begin
                    nErr++; $display("[TB] FAIL rnd%0d_ready C%0d got %0b want %0b", t, k, obsReady[k], (k == expReady));
                end
                nVec++;
                if (obsDone[k] !== (k == expDone)) begin
                    nErr++; $display("[TB] FAIL rnd%0d_done C%0d got %0b want %0b", t, k, obsDone[k], (k == expDone));
                end
                nVec++;
                if (obsBusy[k] !== (k >= 1 && k <= lastBusy)) begin
                    nErr++; $display("[TB] FAIL rnd%0d_busy C%0d got %0b want %0b", t, k, obsBusy[k], (k >= 1 && k <= lastBusy));
                end
            end
            if (rd) begin
                nVec++;
                if (obsLine[expReady] !== modelRdLine) begin
                    nErr++; $display("[TB] FAIL rnd%0d_line got %h want %h", t, obsLine[expReady], modelRdLine);
                end
            end
            nVec++;
            if (obsLine[ncyc] !== modelRdLine) begin
                nErr++; $display("[TB] FAIL rnd%0d_linehold got %h want %h", t, obsLine[ncyc], modelRdLine);
            end
        end
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        test_reset();
        test_write_only();
        test_read_only();
        test_write_read();
        test_hold_rd();
        test_wrap();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
